// File: rtl/spi_shift_engine.sv
// SPI master shift engine: one 8/16/24/32-bit frame per tx handshake, all four CPOL/CPHA modes.
// Frame = SETUP, 2N SCK half-periods, HOLD, each (div+1) cycles; tx_ready_o only in IDLE, rx has no backpressure.
module spi_shift_engine #(
    parameter int NSS_NUM = 4
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               cpol_i,
    input  logic               cpha_i,
    input  logic               lsb_i,
    input  logic [7:0]         div_i,
    input  logic [1:0]         dtb_i,
    input  logic [NSS_NUM-1:0] nss_sel_i,
    input  logic               tx_valid_i,
    output logic               tx_ready_o,
    input  logic [31:0]        tx_data_i,
    output logic               rx_valid_o,
    output logic [31:0]        rx_data_o,
    output logic               busy_o,
    output logic               spi_sck_o,
    output logic               spi_mosi_o,
    input  logic               spi_miso_i,
    output logic [NSS_NUM-1:0] spi_nss_o
);
    typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

    state_t               state_q, state_d;
    logic [7:0]           hcnt_q, hcnt_d;
    logic [6:0]           ecnt_q, ecnt_d;
    logic [7:0]           div_q, div_d;
    logic [1:0]           dtb_q, dtb_d;
    logic                 cpol_q, cpol_d;
    logic                 cpha_q, cpha_d;
    logic                 lsb_q, lsb_d;
    logic [NSS_NUM-1:0]   nss_q, nss_d;
    logic                 sck_q, sck_d;
    logic                 mosi_q, mosi_d;
    logic                 rx_vld_q, rx_vld_d;
    logic [31:0]          tx_q, tx_d;
    logic [31:0]          rx_sh_q, rx_sh_d;
    logic [31:0]          rx_data_q, rx_data_d;

    logic hs, lead_edge, last_edge, sample_ev, shift_ev;

    // The next bit to transmit always sits at bit 0 (LSB-first) or bit N-1 (MSB-first).
    function automatic logic next_bit(input logic [31:0] d, input logic lsb, input logic [1:0] dtb);
        return lsb ? d[0] : d[{dtb, 3'b111}];
    endfunction

    function automatic logic [31:0] shift_tx(input logic [31:0] d, input logic lsb);
        return lsb ? (d >> 1) : (d << 1);
    endfunction

    // LSB-first bits enter at N-1 and drift down, so after N samples the first bit lands at 0.
    function automatic logic [31:0] shift_rx(input logic [31:0] r, input logic b,
                                             input logic lsb, input logic [1:0] dtb);
        return lsb ? ((r >> 1) | (32'(b) << {dtb, 3'b111})) : {r[30:0], b};
    endfunction

    assign hs        = tx_valid_i && (state_q == IDLE);
    assign lead_edge = ~ecnt_q[0];
    assign last_edge = (ecnt_q == {1'b0, dtb_q, 4'hF});
    assign sample_ev = cpha_q ? ~lead_edge : lead_edge;
    assign shift_ev  = cpha_q ? lead_edge : (~lead_edge && ~last_edge);

    always_comb begin
        state_d   = state_q;
        hcnt_d    = hcnt_q;
        ecnt_d    = ecnt_q;
        div_d     = div_q;
        dtb_d     = dtb_q;
        cpol_d    = cpol_q;
        cpha_d    = cpha_q;
        lsb_d     = lsb_q;
        nss_d     = nss_q;
        sck_d     = sck_q;
        mosi_d    = mosi_q;
        rx_vld_d  = 1'b0;
        tx_d      = tx_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        case (state_q)
            IDLE: begin
                if (hs) begin
                    state_d = SETUP;
                    hcnt_d  = div_i;
                    div_d   = div_i;
                    dtb_d   = dtb_i;
                    cpol_d  = cpol_i;
                    cpha_d  = cpha_i;
                    lsb_d   = lsb_i;
                    nss_d   = nss_sel_i;
                    sck_d   = cpol_i;
                    rx_sh_d = '0;
                    // CPHA=0 presents bit 0 during SETUP; CPHA=1 shifts it out on the first leading edge.
                    mosi_d  = next_bit(tx_data_i, lsb_i, dtb_i);
                    tx_d    = cpha_i ? tx_data_i : shift_tx(tx_data_i, lsb_i);
                end
            end
            SETUP: begin
                if (hcnt_q == 8'd0) begin
                    state_d = XFER;
                    hcnt_d  = div_q;
                    ecnt_d  = 7'd0;
                end else begin
                    hcnt_d = hcnt_q - 8'd1;
                end
            end
            XFER: begin
                if (hcnt_q == 8'd0) begin
                    hcnt_d = div_q;
                    sck_d  = ~sck_q;
                    if (sample_ev) begin
                        rx_sh_d = shift_rx(rx_sh_q, spi_miso_i, lsb_q, dtb_q);
                    end
                    if (shift_ev) begin
                        mosi_d = next_bit(tx_q, lsb_q, dtb_q);
                        tx_d   = shift_tx(tx_q, lsb_q);
                    end
                    if (last_edge) begin
                        state_d = HOLD;
                    end else begin
                        ecnt_d = ecnt_q + 7'd1;
                    end
                end else begin
                    hcnt_d = hcnt_q - 8'd1;
                end
            end
            HOLD: begin
                if (hcnt_q == 8'd0) begin
                    state_d   = IDLE;
                    rx_data_d = rx_sh_q;
                    rx_vld_d  = 1'b1;
                    mosi_d    = 1'b0;
                end else begin
                    hcnt_d = hcnt_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            hcnt_q    <= '0;
            ecnt_q    <= '0;
            div_q     <= '0;
            dtb_q     <= '0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            lsb_q     <= 1'b0;
            nss_q     <= '0;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            rx_vld_q  <= 1'b0;
            tx_q      <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            hcnt_q    <= hcnt_d;
            ecnt_q    <= ecnt_d;
            div_q     <= div_d;
            dtb_q     <= dtb_d;
            cpol_q    <= cpol_d;
            cpha_q    <= cpha_d;
            lsb_q     <= lsb_d;
            nss_q     <= nss_d;
            sck_q     <= sck_d;
            mosi_q    <= mosi_d;
            rx_vld_q  <= rx_vld_d;
            tx_q      <= tx_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
        end
    end

    assign tx_ready_o = (state_q == IDLE);
    assign busy_o     = (state_q != IDLE);
    assign rx_valid_o = rx_vld_q;
    assign rx_data_o  = rx_data_q;
    assign spi_sck_o  = sck_q;
    assign spi_mosi_o = mosi_q;
    assign spi_nss_o  = (state_q == IDLE) ? {NSS_NUM{1'b1}} : ~nss_q;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed bench for spi_shift_engine with a behavioural SPI slave and an rx scoreboard.
module tb_spi_shift_engine;
    localparam int NSS_NUM = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               cpol = 1'b1, cpha = 1'b0, lsb = 1'b0;
    logic [7:0]         div = 8'd0;
    logic [1:0]         dtb = 2'd0;
    logic [NSS_NUM-1:0] nss_sel = '0;
    logic               tx_valid = 1'b0;
    logic [31:0]        tx_data = '0;
    logic               tx_ready_o, rx_valid_o, busy_o, spi_sck_o, spi_mosi_o, spi_miso;
    logic [31:0]        rx_data_o;
    logic [NSS_NUM-1:0] spi_nss_o;

    spi_shift_engine #(.NSS_NUM(NSS_NUM)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .cpol_i(cpol), .cpha_i(cpha), .lsb_i(lsb),
        .div_i(div), .dtb_i(dtb), .nss_sel_i(nss_sel), .tx_valid_i(tx_valid),
        .tx_ready_o(tx_ready_o), .tx_data_i(tx_data), .rx_valid_o(rx_valid_o),
        .rx_data_o(rx_data_o), .busy_o(busy_o), .spi_sck_o(spi_sck_o),
        .spi_mosi_o(spi_mosi_o), .spi_miso_i(spi_miso), .spi_nss_o(spi_nss_o)
    );

    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural slave ----------------
    logic        s_cpol = 1'b0, s_cpha = 1'b0, s_lsb = 1'b0, loop_en = 1'b0;
    logic [31:0] s_tx = '0, s_rx = '0;
    int          s_n = 8, s_tcnt = 0, s_rcnt = 0;
    logic        s_miso = 1'b0, s_act, s_act_prev = 1'b0, s_sck_prev = 1'b0, s_lead;

    assign spi_miso = loop_en ? spi_mosi_o : s_miso;

    function automatic logic s_bit(input int k);
        int idx;
        if (k >= s_n) return 1'b0;
        idx = s_lsb ? k : (s_n - 1 - k);
        return s_tx[idx[4:0]];
    endfunction

    always @(negedge clk) begin
        s_act = ~&spi_nss_o;
        if (s_act && !s_act_prev) begin
            s_rx = '0; s_rcnt = 0; s_tcnt = 0;
            if (!s_cpha) begin
                s_miso = s_bit(0);
                s_tcnt = 1;
            end
        end else if (s_act && (spi_sck_o !== s_sck_prev)) begin
            s_lead = (s_sck_prev == s_cpol);
            if (s_lead != s_cpha) begin
                if (s_lsb) s_rx[s_rcnt[4:0]] = spi_mosi_o;
                else       s_rx = {s_rx[30:0], spi_mosi_o};
                s_rcnt++;
            end else begin
                s_miso = s_bit(s_tcnt);
                s_tcnt++;
            end
        end
        s_act_prev = s_act;
        s_sck_prev = spi_sck_o;
    end

    // ---------------- scoreboard monitor ----------------
    typedef struct {
        logic [31:0]        data;
        int                 cycles;
        int                 edges;
        logic [NSS_NUM-1:0] nss;
        logic               cpol;
    } exp_t;

    exp_t               sb_q[$];
    exp_t               m_e;
    int                 m_busy = 0, m_edges = 0;
    logic               m_prev_busy = 1'b0, m_prev_sck = 1'b0;
    logic [NSS_NUM-1:0] m_nss_and = '1, m_nss_or = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_busy = 0; m_edges = 0; m_nss_and = '1; m_nss_or = '0;
        end else begin
            if (busy_o) begin
                m_busy++;
                if (m_prev_busy && (spi_sck_o !== m_prev_sck)) m_edges++;
                m_nss_and &= spi_nss_o;
                m_nss_or  |= spi_nss_o;
            end
            if (rx_valid_o) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_rx_valid", 32'(rx_valid_o), 32'd0);
                end else begin
                    m_e = sb_q.pop_front();
                    check("rx_data", rx_data_o, m_e.data);
                    check("frame_cycles", 32'(m_busy), 32'(m_e.cycles));
                    check("sck_edges", 32'(m_edges), 32'(m_e.edges));
                    check("nss_low_all", 32'(m_nss_and), 32'(m_e.nss));
                    check("nss_low_any", 32'(m_nss_or), 32'(m_e.nss));
                    check("sck_idle", 32'(spi_sck_o), 32'(m_e.cpol));
                    check("mosi_idle", 32'(spi_mosi_o), 32'd0);
                    check("busy_at_rx", 32'(busy_o), 32'd0);
                end
                m_busy = 0; m_edges = 0; m_nss_and = '1; m_nss_or = '0;
            end
        end
        m_prev_busy = busy_o;
        m_prev_sck  = spi_sck_o;
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic c_pol, input logic c_pha, input logic l, input logic [7:0] d,
                         input logic [1:0] t, input logic [NSS_NUM-1:0] sel, input logic [31:0] tx,
                         input logic [31:0] sl_tx, input logic lp, input logic [31:0] exp_rx);
        int n;
        n = 8 * (int'(t) + 1);
        @(negedge clk);
        cpol = c_pol; cpha = c_pha; lsb = l; div = d; dtb = t; nss_sel = sel; tx_data = tx;
        s_cpol = c_pol; s_cpha = c_pha; s_lsb = l; s_n = n; s_tx = sl_tx; loop_en = lp;
        sb_q.push_back('{data: exp_rx, cycles: (int'(d) + 1) * (2 * n + 2), edges: 2 * n,
                         nss: ~sel, cpol: c_pol});
        tx_valid = 1'b1;
    endtask

    task automatic handshake();
        @(posedge clk);
        #1 tx_valid = 1'b0;
    endtask

    task automatic wait_rx(input string name);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (rx_valid_o) break;
        end
        check(name, 32'(rx_valid_o), 32'd1);
    endtask

    task automatic chk_reset(input string tag);
        check({tag, "_tx_ready"}, 32'(tx_ready_o), 32'd1);
        check({tag, "_rx_valid"}, 32'(rx_valid_o), 32'd0);
        check({tag, "_busy"}, 32'(busy_o), 32'd0);
        check({tag, "_rx_data"}, rx_data_o, 32'd0);
        check({tag, "_sck"}, 32'(spi_sck_o), 32'd0);
        check({tag, "_mosi"}, 32'(spi_mosi_o), 32'd0);
        check({tag, "_nss"}, 32'(spi_nss_o), 32'hF);
    endtask

    initial begin
        int  nedge;
        logic prev;
        #12 chk_reset("por");
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("sck_after_reset_cpol_in_1", 32'(spi_sck_o), 32'd0);

        // Mode 0 loopback, 0xA5, exact cycle timing
        issue(1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 4'b0001, 32'h0000_00A5, 32'h0, 1'b1, 32'h0000_00A5);
        handshake();
        @(negedge clk);
        check("m0_setup_busy", 32'(busy_o), 32'd1);
        check("m0_setup_mosi_first", 32'(spi_mosi_o), 32'd1);
        check("m0_setup_sck", 32'(spi_sck_o), 32'd0);
        check("m0_setup_nss", 32'(spi_nss_o), 32'hE);
        wait_rx("m0_rx");
        check("m0_mosi_seq", s_rx, 32'h0000_00A5);

        // Mode 3, LSB first, 32 bits, div 3
        issue(1'b1, 1'b1, 1'b1, 8'd3, 2'd3, 4'b0110, 32'h1234_5678, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D);
        handshake();
        wait_rx("m3_rx");
        check("m3_slave_rx", s_rx, 32'h1234_5678);

        // Mode 1, 16 bits, slave all ones
        issue(1'b0, 1'b1, 1'b0, 8'd2, 2'd1, 4'b1000, 32'h0000_0F0F, 32'h0000_FFFF, 1'b0, 32'h0000_FFFF);
        handshake();
        wait_rx("m1_rx");
        check("m1_slave_rx", s_rx, 32'h0000_0F0F);

        // Mode 2 loopback, LSB first, 24 bits, upper payload bits ignored
        issue(1'b1, 1'b0, 1'b1, 8'd1, 2'd2, 4'b0011, 32'hFFAB_CDEF, 32'h0, 1'b1, 32'h00AB_CDEF);
        handshake();
        wait_rx("m2_rx");
        check("m2_slave_rx", s_rx, 32'h00AB_CDEF);

        // tx_valid held high: second frame taken in the rx_valid cycle
        issue(1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 4'b0001, 32'h0000_003C, 32'h0000_0096, 1'b0, 32'h0000_0096);
        sb_q.push_back(sb_q[sb_q.size() - 1]);
        wait_rx("b2b_first_rx");
        check("b2b_gap_nss", 32'(spi_nss_o), 32'hF);
        check("b2b_gap_ready", 32'(tx_ready_o), 32'd1);
        @(posedge clk);
        #1 tx_valid = 1'b0;
        @(negedge clk);
        check("b2b_second_busy", 32'(busy_o), 32'd1);
        check("b2b_second_nss", 32'(spi_nss_o), 32'hE);
        wait_rx("b2b_second_rx");
        check("b2b_slave_rx", s_rx, 32'h0000_003C);

        // Config changes and tx_valid pulses mid-frame must not disturb the frame
        issue(1'b0, 1'b0, 1'b1, 8'd1, 2'd1, 4'b0101, 32'h0000_BEEF, 32'h0000_1357, 1'b0, 32'h0000_1357);
        handshake();
        repeat (10) @(negedge clk);
        div = 8'd7; dtb = 2'd3; nss_sel = 4'b1010; cpol = 1'b1; lsb = 1'b0;
        tx_data = 32'h1111_1111; tx_valid = 1'b1;
        repeat (3) @(negedge clk);
        tx_valid = 1'b0;
        wait_rx("midchg_rx");
        check("midchg_slave_rx", s_rx, 32'h0000_BEEF);

        // Reset at XFER edge 5 aborts the frame
        issue(1'b1, 1'b0, 1'b0, 8'd1, 2'd1, 4'b0010, 32'h0000_1234, 32'h0, 1'b0, 32'h0);
        handshake();
        @(negedge clk);
        prev = spi_sck_o;
        nedge = 0;
        for (int i = 0; i < 500 && nedge < 6; i++) begin
            @(negedge clk);
            if (spi_sck_o !== prev) nedge++;
            prev = spi_sck_o;
        end
        check("rst_edge_reached", 32'(nedge), 32'd6);
        check("rst_busy_before", 32'(busy_o), 32'd1);
        #2 rst_n = 1'b0;
        sb_q.delete();
        #1 chk_reset("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (80) @(negedge clk);
        check("post_rst_busy", 32'(busy_o), 32'd0);
        check("post_rst_rx_data", rx_data_o, 32'd0);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d checks made", vec_cnt);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/spi_shift_engine.md
SPI_SHIFT_ENGINE -- requirements
Module: spi_shift_engine

Interface
REQ-001 Parameter: NSS_NUM, default 4, number of slave-select lines.
REQ-002 clk_i  input  1  block clock; one clock domain, all logic on its rising edge.
REQ-003 rst_n_i  input  1  reset, asynchronous assert, active-low.
REQ-004 cpol_i / cpha_i / lsb_i  input  1 each  SCK idle level / sample phase / LSB-first select.
REQ-005 div_i  input  8  SCK half-period in clk_i cycles, minus 1; 0 gives half-period 1.
REQ-006 dtb_i  input  2  frame length; bit count N = 8*(dtb_i+1), so 8/16/24/32.
REQ-007 nss_sel_i  input  NSS_NUM  slaves to select during a frame; 1 = select.
REQ-008 tx_valid_i / tx_ready_o  in/out  1 each  frame-start handshake.
REQ-009 tx_data_i  input  32  frame payload, right-aligned.
REQ-010 rx_valid_o  output  1  one-cycle pulse, received frame valid.
REQ-011 rx_data_o  output  32  received frame, right-aligned.
REQ-012 busy_o  output  1  high in any state other than IDLE.
REQ-013 spi_sck_o / spi_mosi_o  output  1 each  serial clock / data out.
REQ-014 spi_miso_i  input  1  serial data in.
REQ-015 spi_nss_o  output  NSS_NUM  active-low slave selects.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, SETUP, XFER and HOLD.
REQ-017 tx_ready_o SHALL equal 1 only in IDLE.
REQ-018 A handshake (tx_valid_i & tx_ready_o) SHALL:
- latch tx_data_i, cpol_i, cpha_i, lsb_i, div_i, dtb_i and nss_sel_i;
- move the FSM to SETUP.
REQ-019 Input changes after the handshake SHALL NOT affect the frame in progress.
REQ-020 In SETUP, XFER and HOLD, spi_nss_o SHALL equal ~latched nss_sel; in IDLE it SHALL be all ones.
REQ-021 Phase lengths:
- SETUP lasts div+1 cycles with spi_sck_o = cpol;
- XFER lasts 2*N*(div+1) cycles, toggling spi_sck_o every div+1 cycles;
- HOLD lasts div+1 cycles with spi_sck_o = cpol.
REQ-022 Bit order: bit 0 is sent first when lsb=1, otherwise bit N-1 is sent first.
REQ-023 cpha=0:
- the first bit SHALL be on spi_mosi_o from the start of SETUP;
- sample spi_miso_i on each leading edge;
- shift spi_mosi_o on each trailing edge except the last.
REQ-024 cpha=1:
- shift spi_mosi_o on each leading edge, including the first;
- sample on each trailing edge.
REQ-025 Received bits SHALL be assembled in the same order as transmitted, so that rx_data_o[N-1:0] is the natural value and rx_data_o[31:N] = 0.
REQ-026 When HOLD ends, the FSM SHALL go to IDLE with rx_valid_o = 1 for that first IDLE cycle; rx_data_o SHALL stay stable until the next frame completes.
REQ-027 A handshake in the same cycle as the rx_valid_o pulse SHALL be accepted, giving at least one IDLE cycle with all NSS high between frames.
REQ-028 tx_valid_i while busy SHALL be ignored, with no state change and no loss of the current frame.
REQ-029 rx_valid_o has no backpressure; a frame not consumed SHALL be overwritten by the next one.
REQ-030 spi_mosi_o SHALL be 0 in IDLE.
REQ-031 All counters SHALL be sized for the worst case:
- half-period counter: 8 bits;
- edge counter: 7 bits (up to 64 edges).

Reset
REQ-032 While rst_n_i = 0, the block SHALL immediately force:
- FSM = IDLE; tx_ready_o = 1; rx_valid_o = 0; busy_o = 0;
- rx_data_o = 0; spi_sck_o = 0; spi_mosi_o = 0; spi_nss_o = all ones.
REQ-033 A reset mid-frame SHALL abort the frame with no rx_valid_o pulse.
REQ-034 After reset deassertion, spi_sck_o SHALL follow cpol_i only once the next frame is latched.

Verification
REQ-035 Mode 0 loopback (MOSI tied to MISO), cpol=0 cpha=0 lsb=0 div=0 dtb=0, tx 0xA5, handshake at edge T:
- SETUP is cycle T+1;
- XFER is T+2..T+17 with 8 SCK pulses;
- HOLD is T+18;
- rx_valid_o = 1 at T+19 with rx_data_o = 0x000000A5;
- MOSI sequence is 1,0,1,0,0,1,0,1.
REQ-036 Mode 3 LSB-first, cpol=1 cpha=1 lsb=1 div=3 dtb=3, tx 0x12345678:
- the slave model receives 0x12345678 LSB-first;
- SCK idles high;
- the frame lasts 4+256+4 cycles;
- a slave driving 0xCAFEF00D gives rx_data_o = 0xCAFEF00D.
REQ-037 16-bit frame with the slave driving 0xFFFF: rx_data_o = 0x0000FFFF.
REQ-038 tx_valid_i held high through a frame:
- the second frame is accepted in the rx_valid_o cycle;
- NSS is high for exactly one cycle between frames.
REQ-039 Mid-frame changes: altering div_i, dtb_i and nss_sel_i mid-frame has no effect on SCK timing, bit count or NSS.
REQ-040 rst_n_i pulsed low at XFER edge 5: outputs reach reset values asynchronously and no rx_valid_o follows.
